// File: rtl/mic_frame_sequencer.sv
// mic_frame_sequencer: captures ADC frames on strobe edges, buffers them, and serialises samples onto a valid/ready stream.
// Optional MIC_SEQ_DROP_CNT_EN adds a saturating dropped-frame counter output.
module mic_frame_sequencer #(
    parameter int NUM_CH      = 6,
    parameter int DATA_W      = 16,
    parameter int DEPTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk_clk,
    input  logic                     reset_reset_n,
    input  logic                     clk_for_data,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    input  logic                     enable,
    output logic [DATA_W-1:0]        out_data,
    output logic [2:0]               out_ch,
    output logic                     out_sof,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     overflow,
    input  logic                     clr_overflow
`ifdef MIC_SEQ_DROP_CNT_EN
    ,
    output logic [15:0]              drop_cnt
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [2:0] LAST = 3'(NUM_CH - 1);
    localparam logic [0:0] IDLE = 1'b0, SEND = 1'b1;

    logic [SYNC_STAGES-1:0]   sync_q;
    logic                     edge_q;
    logic [AW:0]              wr_ptr, rd_ptr;
    logic [NUM_CH*DATA_W-1:0] mem [DEPTH];
    logic [NUM_CH*DATA_W-1:0] frame_q;
    logic [0:0]               state;
    logic                     hs, last, pop, cap, push, drop;

    assign fifo_level = wr_ptr - rd_ptr;
    assign out_valid  = state == SEND;
    assign hs         = out_valid & out_ready;
    assign last       = out_ch == LAST;
    assign pop        = (fifo_level != '0) & ((state == IDLE) | (hs & last));
    assign cap        = edge_q & enable;
    // level never exceeds DEPTH, so its MSB alone marks a full FIFO
    assign push       = cap & (~fifo_level[AW] | pop);
    assign drop       = cap & ~push;
    assign out_data   = frame_q[out_ch*DATA_W +: DATA_W];

    always_ff @(posedge clk_clk)
        if (push) mem[wr_ptr[AW-1:0]] <= ch_data;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            sync_q   <= '0;
            edge_q   <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            frame_q  <= '0;
            out_ch   <= 3'd0;
            out_sof  <= 1'b0;
            state    <= IDLE;
            overflow <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], clk_for_data};
            edge_q   <= sync_q[SYNC_STAGES-2] & ~sync_q[SYNC_STAGES-1];
            overflow <= drop | (overflow & ~clr_overflow);
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr  <= rd_ptr + 1'b1;
                frame_q <= mem[rd_ptr[AW-1:0]];
                out_ch  <= 3'd0;
                out_sof <= 1'b1;
                state   <= SEND;
            end else if (hs & last) begin
                state   <= IDLE;
            end else if (hs) begin
                out_ch  <= out_ch + 3'd1;
                out_sof <= 1'b0;
            end
        end
    end

`ifdef MIC_SEQ_DROP_CNT_EN
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) drop_cnt <= 16'd0;
        else drop_cnt <= clr_overflow ? {15'd0, drop} : (drop & ~&drop_cnt) ? drop_cnt + 16'd1 : drop_cnt;
    end
`endif
endmodule

// File: tb/tb_mic_frame_sequencer.sv
// tb_mic_frame_sequencer: table-driven and scoreboarded checks of frame capture, buffering and serialised readout.
module tb_mic_frame_sequencer;
    typedef struct packed {
        logic [15:0] d;
        logic [2:0]  ch;
        logic        sof;
    } beat_t;

    typedef struct {
        logic [95:0] data;
        logic        en;
        int          exp_beats;
    } vec_t;

    logic        clk = 1'b0, rst_n = 1'b0, cfd = 1'b0, enable = 1'b0, out_ready = 1'b0, clr = 1'b0;
    logic [95:0] ch_data = '0;
    logic [15:0] out_data;
    logic [2:0]  out_ch;
    logic        out_sof, out_valid, overflow;
    logic [3:0]  fifo_level;
`ifdef MIC_SEQ_DROP_CNT_EN
    logic [15:0] drop_cnt;
`endif

    int    checks = 0, errors = 0, beats = 0, b0;
    beat_t q[$];
    beat_t prev, act;
    logic  stall_prev = 1'b0, nobubble = 1'b0;
    vec_t  vec [4];

    mic_frame_sequencer dut (
        .clk_clk(clk), .reset_reset_n(rst_n), .clk_for_data(cfd), .ch_data(ch_data),
        .enable(enable), .out_data(out_data), .out_ch(out_ch), .out_sof(out_sof),
        .out_valid(out_valid), .out_ready(out_ready), .fifo_level(fifo_level),
        .overflow(overflow), .clr_overflow(clr)
`ifdef MIC_SEQ_DROP_CNT_EN
        , .drop_cnt(drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
        $fatal(1);
    end

    always @(negedge clk) begin
        if (rst_n) begin
            act = {out_data, out_ch, out_sof};
            if (stall_prev) begin
                checks++;
                if (!out_valid || act != prev) begin
                    errors++;
                    $display("FAIL stall_hold: got valid=%0b beat=%h expected valid=1 beat=%h", out_valid, act, prev);
                end
            end
            if (nobubble && q.size() > 0) begin
                checks++;
                if (!out_valid) begin
                    errors++;
                    $display("FAIL bubble: got out_valid=0 expected 1 with %0d beats pending", q.size());
                end
            end
            if (out_valid && out_ready) begin
                beats++;
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat: got beat=%h expected no beat", act);
                end else begin
                    prev = q.pop_front();
                    if (act != prev) begin
                        errors++;
                        $display("FAIL beat: got d=%h ch=%0d sof=%0b expected d=%h ch=%0d sof=%0b",
                                 out_data, out_ch, out_sof, prev.d, prev.ch, prev.sof);
                    end
                end
            end
            stall_prev = out_valid && !out_ready;
            prev = act;
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic void push_frame(input logic [95:0] d);
        for (int c = 0; c < 6; c++) q.push_back('{d[c*16 +: 16], 3'(c), c == 0});
    endfunction

    task automatic strobe(input logic [95:0] d, input logic exp);
        ch_data = d;
        cfd = 1'b1;
        if (exp) push_frame(d);
        cyc(4);
        cfd = 1'b0;
        cyc(2);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 500; i++) begin
            if (q.size() == 0 && !out_valid) break;
            cyc(1);
        end
        chk("drain", {31'd0, q.size() == 0 && !out_valid}, 32'd1);
    endtask

    initial begin
        vec[0] = '{96'h0006_0005_0004_0003_0002_0001, 1'b1, 6};
        vec[1] = '{96'hFFFF_0000_FFFF_0000_FFFF_0000, 1'b1, 6};
        vec[2] = '{96'hDEAD_BEEF_CAFE_F00D_1234_5678, 1'b0, 0};
        vec[3] = '{96'hA5A5_5A5A_8001_7FFE_0F0F_F0F0, 1'b1, 6};

        cyc(2);
        chk("rst_valid", out_valid, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_ch", out_ch, 0);
        chk("rst_sof", out_sof, 0);
        chk("rst_data", out_data, 0);
        rst_n = 1'b1;
        enable = 1'b1;
        out_ready = 1'b1;
        cyc(2);

        // T1: edge-to-write latency and beat order
        ch_data = 96'h6666_5555_4444_3333_2222_1111;
        cfd = 1'b1;
        push_frame(ch_data);
        cyc(2);
        chk("t1_level_early", fifo_level, 0);
        cyc(1);
        chk("t1_level_write", fifo_level, 1);
        cyc(1);
        cfd = 1'b0;
        cyc(2);
        wait_drain();

        for (int i = 0; i < 4; i++) begin
            enable = vec[i].en;
            b0 = beats;
            strobe(vec[i].data, vec[i].en);
            wait_drain();
            chk($sformatf("vec%0d_beats", i), beats - b0, vec[i].exp_beats);
            chk($sformatf("vec%0d_level", i), fifo_level, 0);
        end
        enable = 1'b1;

        // T2: first frame sits in the output register, eight more fill the FIFO
        out_ready = 1'b0;
        for (int i = 0; i < 9; i++) strobe({6{16'(16'h1000 + i)}} ^ 96'h0000_0001_0002_0003_0004_0005, 1'b1);
        chk("t2_full_level", fifo_level, 8);
        chk("t2_no_overflow", overflow, 0);
        strobe({6{16'hBAD0}}, 1'b0);
        chk("t2_drop_level", fifo_level, 8);
        chk("t2_overflow", overflow, 1);
`ifdef MIC_SEQ_DROP_CNT_EN
        chk("t2_drop_cnt", drop_cnt, 1);
`endif
        clr = 1'b1;
        cyc(1);
        clr = 1'b0;
        chk("t2_clr", overflow, 0);
`ifdef MIC_SEQ_DROP_CNT_EN
        chk("t2_clr_cnt", drop_cnt, 0);
`endif

        // T4: write lands on the same edge as the last-beat pop
        out_ready = 1'b1;
        cyc(3);
        ch_data = 96'h4444_4444_4444_4444_4444_4444 ^ 96'h0005_0004_0003_0002_0001_0000;
        cfd = 1'b1;
        push_frame(ch_data);
        cyc(3);
        out_ready = 1'b0;
        chk("t4_level", fifo_level, 8);
        chk("t4_overflow", overflow, 0);
        cyc(1);
        cfd = 1'b0;
        cyc(2);
        out_ready = 1'b1;
        wait_drain();

        // T3: alternating ready over three queued frames
        out_ready = 1'b0;
        strobe(96'h3A06_3A05_3A04_3A03_3A02_3A01, 1'b1);
        strobe(96'h3B06_3B05_3B04_3B03_3B02_3B01, 1'b1);
        strobe(96'h3C06_3C05_3C04_3C03_3C02_3C01, 1'b1);
        b0 = beats;
        nobubble = 1'b1;
        for (int i = 0; i < 200 && q.size() > 0; i++) begin
            out_ready = ~out_ready;
            cyc(1);
        end
        nobubble = 1'b0;
        chk("t3_beats", beats - b0, 18);
        out_ready = 1'b1;
        wait_drain();

        // T5: disabling capture still drains queued frames
        out_ready = 1'b0;
        strobe(96'h5106_5105_5104_5103_5102_5101, 1'b1);
        strobe(96'h5206_5205_5204_5203_5202_5201, 1'b1);
        enable = 1'b0;
        out_ready = 1'b1;
        b0 = beats;
        for (int i = 0; i < 3; i++) strobe({6{16'hEEEE}}, 1'b0);
        wait_drain();
        chk("t5_beats", beats - b0, 12);
        chk("t5_valid", out_valid, 0);
        chk("t5_level", fifo_level, 0);
        chk("t5_overflow", overflow, 0);

        // T6: reset in the middle of an output frame
        enable = 1'b1;
        out_ready = 1'b0;
        strobe(96'h6106_6105_6104_6103_6102_6101, 1'b1);
        strobe(96'h6206_6205_6204_6203_6202_6201, 1'b1);
        out_ready = 1'b1;
        cyc(3);
        out_ready = 1'b0;
        chk("t6_mid_ch", out_ch, 3);
        rst_n = 1'b0;
        #1;
        chk("t6_valid", out_valid, 0);
        chk("t6_level", fifo_level, 0);
        chk("t6_overflow", overflow, 0);
        chk("t6_ch", out_ch, 0);
        q.delete();
        cyc(2);
        rst_n = 1'b1;
        out_ready = 1'b1;
        cyc(1);
        strobe(96'h6306_6305_6304_6303_6302_6301, 1'b1);
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
